// File: rtl/bus_mux_reg.sv
// Registered priority bus multiplexer with conflict detection and a configurable idle policy.
// Define BUS_PARITY_EN to add the registered even-parity output bus_par.
module bus_mux_reg #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NUM_SRC   = 24,
    parameter int unsigned SEL_W     = $clog2(NUM_SRC),
    parameter int unsigned HOLD_IDLE = 1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]       src_out,
    input  logic                     conflict_clr,
    output logic [WIDTH-1:0]         bus_out,
    output logic                     bus_valid,
    output logic [SEL_W-1:0]         bus_src,
    output logic                     conflict,
    output logic                     conflict_sticky,
`ifdef BUS_PARITY_EN
    output logic                     bus_par,
`endif
    output logic [CNT_W-1:0]         conflict_cnt
);

    logic [WIDTH-1:0] bus_d, bus_q;
    logic             valid_d, valid_q;
    logic [SEL_W-1:0] src_d, src_q;
    logic             conf_d, conf_q;
    logic             sticky_d, sticky_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             par_d, par_q;

    logic [WIDTH-1:0] sel_data;
    logic [SEL_W-1:0] sel_idx;
    logic             any_act;
    logic             multi_act;

    // Scan downwards so the lowest-numbered active strobe is the last one written.
    always_comb begin
        sel_data = '0;
        sel_idx  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_out[i]) begin
                sel_data = src_data[i*WIDTH +: WIDTH];
                sel_idx  = SEL_W'(i);
            end
        end
    end

    assign any_act   = |src_out;
    assign multi_act = |(src_out & (src_out - NUM_SRC'(1)));

    always_comb begin
        bus_d    = bus_q;
        valid_d  = 1'b0;
        src_d    = src_q;
        par_d    = par_q;
        conf_d   = multi_act;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;

        if (any_act) begin
            bus_d   = sel_data;
            valid_d = 1'b1;
            src_d   = sel_idx;
            par_d   = ^sel_data;
        end else if (HOLD_IDLE == 0) begin
            bus_d = '0;
            par_d = 1'b0;
        end

        // A clear request wins over a conflict in the same cycle.
        if (conflict_clr) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end else if (multi_act) begin
            sticky_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            bus_q    <= '0;
            valid_q  <= 1'b0;
            src_q    <= '0;
            conf_q   <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            par_q    <= 1'b0;
        end else begin
            bus_q    <= bus_d;
            valid_q  <= valid_d;
            src_q    <= src_d;
            conf_q   <= conf_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            par_q    <= par_d;
        end
    end

    assign bus_out         = bus_q;
    assign bus_valid       = valid_q;
    assign bus_src         = src_q;
    assign conflict        = conf_q;
    assign conflict_sticky = sticky_q;
    assign conflict_cnt    = cnt_q;

`ifdef BUS_PARITY_EN
    assign bus_par = par_q;
`else
    logic unused_par;
    assign unused_par = par_q;
`endif

endmodule

// File: doc/bus_mux_reg.md
Name: bus_mux_reg

Overview:
- Parametrised, registered successor to the datapath bus multiplexer.
- Takes NUM_SRC one-hot "out" strobes from the control unit and NUM_SRC data sources of WIDTH bits, and drives a single registered bus.
- Adds priority resolution on multi-hot strobes, conflict detection and counting, and a selectable idle policy (hold last value or drive zero).
- Sits between the register file/special registers (HI, LO, Z, PC, MDR, InPort, C) and every bus consumer.

Parameters:
- WIDTH, 32, data width of every source and of the bus.
- NUM_SRC, 24, number of bus sources; must be 2..64.
- SEL_W, $clog2(NUM_SRC), width of the encoded source index.
- HOLD_IDLE, 1, 1 = bus keeps its last driven value when no strobe is active; 0 = bus goes to zero.
- CNT_W, 8, width of the saturating conflict counter.

Ports:
- clock  input  1  rising-edge clock.
- clear  input  1  asynchronous, active-low reset.
- src_data  input  NUM_SRC*WIDTH  packed sources; source i occupies bits [i*WIDTH +: WIDTH].
- src_out  input  NUM_SRC  drive strobes; bit i requests source i onto the bus.
- conflict_clr  input  1  synchronous clear of conflict_sticky and conflict_cnt.
- bus_out  output  WIDTH  registered bus value.
- bus_valid  output  1  high when bus_out was loaded from a source in the previous cycle.
- bus_src  output  SEL_W  index of the source currently on bus_out.
- conflict  output  1  single-cycle pulse: more than one strobe was active in the previous cycle.
- conflict_sticky  output  1  set by any conflict; held until conflict_clr or reset.
- conflict_cnt  output  CNT_W  saturating count of conflict cycles.

Behaviour:
- Reset (clear=0, asynchronous): bus_out=0, bus_valid=0, bus_src=0, conflict=0, conflict_sticky=0, conflict_cnt=0. Release is sampled at the next rising edge.
- Latency:
  - One cycle from src_out/src_data to bus_out, bus_valid, bus_src and conflict.
  - Registers load on every rising edge; there is no enable.
- Encoding: the lowest-numbered active strobe wins (priority encoder). Higher indices are ignored for data.
- Exactly one strobe active (index k): bus_out <= source k, bus_src <= k, bus_valid <= 1, conflict <= 0.
- Two or more strobes active:
  - Lowest index k drives the bus: bus_out <= source k, bus_src <= k, bus_valid <= 1.
  - conflict <= 1 and conflict_sticky <= 1.
  - conflict_cnt increments by 1 and saturates at 2^CNT_W-1 (no wrap).
- No strobe active:
  - bus_valid <= 0, conflict <= 0, and bus_src holds its value.
  - HOLD_IDLE=1: bus_out holds its last value.
  - HOLD_IDLE=0: bus_out <= 0.
- conflict_clr=1:
  - conflict_sticky <= 0 and conflict_cnt <= 0.
  - Takes priority over a simultaneous conflict for the sticky flag and the counter. The conflict pulse still asserts for that cycle.
- Strobe bits at index >= NUM_SRC do not exist. Source indices beyond a design's real sources must be tied to 0.
- Reset asserted mid-transfer: all outputs return to reset values immediately. The first cycle after release behaves as idle unless a strobe is active.
- Purely synchronous datapath after reset; no combinational path from inputs to outputs.

Optional Feature:
- Macro: BUS_PARITY_EN.
- Defined:
  - Adds output bus_par (1 bit), the registered even parity (XOR reduction) of the value loaded into bus_out, with the same one-cycle latency.
  - Reset value 0.
  - bus_par is recomputed whenever bus_out is loaded (including zero under HOLD_IDLE=0) and held whenever bus_out holds.
- Undefined: port bus_par and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: clear=0 with src_out=24'hFFFFFF -> all outputs 0. After release with src_out=0, outputs stay 0 under HOLD_IDLE=1.
- Single drive: src_data[5]=32'hDEADBEEF, src_out=1<<5 for one cycle, then 0 -> next cycle bus_out=32'hDEADBEEF, bus_src=5, bus_valid=1, conflict=0. The following cycle bus_valid=0 and bus_out holds 32'hDEADBEEF (HOLD_IDLE=1), or becomes 0 (HOLD_IDLE=0 build).
- Conflict: src_out=(1<<3)|(1<<20), src_data[3]=32'h00000003 -> bus_out=32'h3, bus_src=3, conflict pulses for one cycle, conflict_sticky=1, conflict_cnt=1. Drive the same strobes 300 cycles -> conflict_cnt=255 (CNT_W=8).
- conflict_clr together with a conflict: conflict_clr=1 in a multi-hot cycle -> conflict=1 next cycle, conflict_sticky=0, conflict_cnt=0.
- Back-to-back sources: cycles drive src 0 (32'h1), src 23 (32'h80000000), src 12 (32'h5A5A5A5A) -> bus_out follows one cycle later with bus_src 0, 23, 12 and bus_valid=1 throughout.
- Async reset mid-stream plus parity (BUS_PARITY_EN): drive 32'h00000007 -> bus_par=1. Pull clear low between clock edges -> bus_out=0 and bus_par=0 immediately, without waiting for a clock edge.
